// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned BAUD_W    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: latches the period on load and ticks once per period while enabled.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned BaseDiv = 16,
  parameter int unsigned CntW    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [BAUD_W-1:0] baud_i,
  output logic              tick_o
);

  localparam logic [CntW-1:0] One = CntW'(1);

  logic [CntW-1:0] period_q, period_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] reload;

  always_comb begin
    reload   = CntW'(BaseDiv) << baud_i;
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      period_d = reload;
      cnt_d    = reload - One;
    end else if (en_i) begin
      // Wrap straight to the next period so consecutive bits have no gap.
      cnt_d = (cnt_q == '0) ? (period_q - One) : (cnt_q - One);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= CntW'(BaseDiv);
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX FIFO and serialises each byte as start/data/stop.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BASE_DIV = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              txen,
  input  logic              txst,
  input  logic [BAUD_W-1:0] baud,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_rdata,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic              fifo_ren,
  output logic              txd,
  output logic              busy,
  output logic              busy_en,
  output logic              tx_done_set
);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       pend_q, pend_d;
  logic       busy_en_q, busy_en_d;
  logic       done_q, done_d;
  logic       cnt_load, cnt_en, tick;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  uart_baud_cnt #(
    .BaseDiv (BASE_DIV),
    .CntW    (CNT_W)
  ) u_baud_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .baud_i (baud),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    fifo_ren = 1'b0;
    txd      = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    // A force-start with nothing to send is dropped.
    if (txst && !fifo_empty) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && (txen || pend_q)) begin
          state_d = StLoad;
          pend_d  = 1'b0;
        end
      end
      StLoad: begin
        fifo_ren = !fifo_empty;
        shift_d  = fifo_rdata;
        bit_d    = '0;
        cnt_load = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d    = (^fifo_rdata) ^ parity_odd;
`endif
        state_d  = StStart;
      end
      StStart: begin
        txd    = 1'b0;
        cnt_en = 1'b1;
        if (tick) state_d = StData;
      end
      StData: begin
        txd    = shift_q[0];
        cnt_en = 1'b1;
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        txd    = par_q;
        cnt_en = 1'b1;
        if (tick) state_d = StStop;
      end
`endif
      StStop: begin
        cnt_en = 1'b1;
        if (tick) begin
          if (!fifo_empty && txen) begin
            state_d = StLoad;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
            done_d  = fifo_empty;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_en_d = (state_d != StIdle) != (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_q     <= '0;
      pend_q    <= 1'b0;
      busy_en_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      pend_q    <= pend_d;
      busy_en_q <= busy_en_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign busy        = (state_q != StIdle);
  assign busy_en     = busy_en_q;
  assign tx_done_set = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with BASE_DIV=4; outputs are traced at every falling edge.
module tb_uart_tx_ctrl;

  localparam int TR = 4096;
  localparam int P0 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * P0 + 1;
  localparam int SEL_REN = 0, SEL_DONE = 1, SEL_BEN = 2, SEL_BUSY = 3;

  logic       clk = 1'b0;
  logic       rst, txen, txst;
  logic [1:0] baud;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_ren, txd, busy, busy_en, tx_done_set;
`ifdef UART_TX_PARITY_EN
  logic       par_odd;
`endif

  logic [7:0] fifo_mem [16];
  logic [3:0] rd_ptr = '0;
  logic [3:0] wr_ptr = '0;

  bit tr_txd [TR];
  bit tr_ren [TR];
  bit tr_done[TR];
  bit tr_ben [TR];
  bit tr_busy[TR];
  int cyc = 0;
  int ren_viol = 0;
  int n_checks = 0;
  int n_errors = 0;

  uart_tx_ctrl #(
    .BASE_DIV (4),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .txen        (txen),
    .txst        (txst),
    .baud        (baud),
    .fifo_empty  (fifo_empty),
    .fifo_rdata  (fifo_rdata),
`ifdef UART_TX_PARITY_EN
    .parity_odd  (par_odd),
`endif
    .fifo_ren    (fifo_ren),
    .txd         (txd),
    .busy        (busy),
    .busy_en     (busy_en),
    .tx_done_set (tx_done_set)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = fifo_mem[rd_ptr];

  always @(posedge clk) if (fifo_ren) rd_ptr <= rd_ptr + 4'd1;

  always @(negedge clk) begin
    tr_txd[cyc % TR]  <= txd;
    tr_ren[cyc % TR]  <= fifo_ren;
    tr_done[cyc % TR] <= tx_done_set;
    tr_ben[cyc % TR]  <= busy_en;
    tr_busy[cyc % TR] <= busy;
    if (fifo_ren && fifo_empty) ren_viol <= ren_viol + 1;
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line image indexed by bit time: [0] start, [8:1] data LSB first, then parity/stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, (^d) ^ par_odd, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  function automatic int cnt_sig(input int sel, input int from, input int n);
    int c = 0;
    for (int i = from; i < from + n; i++) begin
      case (sel)
        SEL_REN:  c += tr_ren[i % TR] ? 1 : 0;
        SEL_DONE: c += tr_done[i % TR] ? 1 : 0;
        SEL_BEN:  c += tr_ben[i % TR] ? 1 : 0;
        default:  c += tr_busy[i % TR] ? 1 : 0;
      endcase
    end
    return c;
  endfunction

  // base is the trace index of the LOAD cycle.
  task automatic frame_check(input string tag, input int base, input int p, input logic [7:0] d);
    logic [10:0] obs, exp;
    int hold_err;
    exp = frame_bits(d);
    obs = '0;
    hold_err = 0;
    for (int j = 0; j < NB; j++) begin
      obs[j] = tr_txd[(base + 1 + p * j) % TR];
      for (int k = 0; k < p; k++)
        if (tr_txd[(base + 1 + p * j + k) % TR] != exp[j]) hold_err++;
    end
    check_eq({tag, "_bits"}, 32'(obs), 32'(exp));
    check_eq({tag, "_hold"}, hold_err, 0);
    check_eq({tag, "_ren"}, 32'(tr_ren[base % TR]), 1);
    check_eq({tag, "_load_txd"}, 32'(tr_txd[base % TR]), 1);
  endtask

  initial begin
    int mark, base, base2, fl2;
    rst  = 1'b1;
    txen = 1'b0;
    txst = 1'b0;
    baud = 2'd0;
`ifdef UART_TX_PARITY_EN
    par_odd = 1'b0;
`endif
    repeat (3) tick();
    check_eq("rst_txd", 32'(txd), 1);
    check_eq("rst_ren", 32'(fifo_ren), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_busy_en", 32'(busy_en), 0);
    check_eq("rst_done", 32'(tx_done_set), 0);
    rst = 1'b0;
    tick();

    // Single byte 0xA5: LOAD one cycle after data, txd low the cycle after.
    mark = cyc;
    push(8'hA5);
    txen = 1'b1;
    repeat (FL + 5) tick();
    base = mark + 1;
    check_eq("a5_idle_txd", 32'(tr_txd[mark % TR]), 1);
    frame_check("a5", base, P0, 8'hA5);
    check_eq("a5_ren_cnt", cnt_sig(SEL_REN, mark, FL + 5), 1);
    check_eq("a5_done_at_end", 32'(tr_done[(base + FL) % TR]), 1);
    check_eq("a5_done_cnt", cnt_sig(SEL_DONE, mark, FL + 5), 1);
    check_eq("a5_ben_start", 32'(tr_ben[base % TR]), 1);
    check_eq("a5_ben_end", 32'(tr_ben[(base + FL) % TR]), 1);
    check_eq("a5_ben_cnt", cnt_sig(SEL_BEN, mark, FL + 5), 2);
    check_eq("a5_busy_end", 32'(tr_busy[(base + FL) % TR]), 0);

    // Back-to-back 0x00 then 0xFF.
    mark = cyc;
    push(8'h00);
    push(8'hFF);
    repeat (2 * FL + 5) tick();
    base  = mark + 1;
    base2 = base + FL;
    frame_check("b2b0", base, P0, 8'h00);
    frame_check("b2b1", base2, P0, 8'hFF);
    check_eq("b2b_gap_start", 32'(tr_txd[(base2 + 1) % TR]), 0);
    check_eq("b2b_done_cnt", cnt_sig(SEL_DONE, mark, 2 * FL + 5), 1);
    check_eq("b2b_done_at_end", 32'(tr_done[(base2 + FL) % TR]), 1);
    check_eq("b2b_ben_cnt", cnt_sig(SEL_BEN, mark, 2 * FL + 5), 2);
    txen = 1'b0;

    // txen low: data waits for a force-start.
    mark = cyc;
    push(8'h3C);
    repeat (4) tick();
    check_eq("txen0_no_pop", cnt_sig(SEL_REN, mark, 4), 0);
    mark = cyc;
    txst = 1'b1;
    tick();
    txst = 1'b0;
    repeat (FL + 6) tick();
    base = mark + 2;
    frame_check("txst", base, P0, 8'h3C);
    check_eq("txst_ren_cnt", cnt_sig(SEL_REN, mark, FL + 7), 1);
    check_eq("txst_done", 32'(tr_done[(base + FL) % TR]), 1);

    // Force-start on an empty FIFO is dropped, so later data stays put.
    mark = cyc;
    txst = 1'b1;
    tick();
    txst = 1'b0;
    repeat (6) tick();
    push(8'h55);
    repeat (6) tick();
    check_eq("txst_empty_ren", cnt_sig(SEL_REN, mark, 13), 0);
    check_eq("txst_empty_busy", cnt_sig(SEL_BUSY, mark, 13), 0);
    wr_ptr = rd_ptr;
    tick();

    // Baud 0->3 during DATA of the first frame.
    mark = cyc;
    txen = 1'b1;
    push(8'h5A);
    push(8'hC3);
    repeat (16) tick();
    baud = 2'd3;
    fl2 = NB * 32 + 1;
    repeat (FL + fl2 + 5 - 16) tick();
    base  = mark + 1;
    base2 = base + FL;
    frame_check("baud_f1", base, P0, 8'h5A);
    frame_check("baud_f2", base2, 32, 8'hC3);
    check_eq("baud_done", 32'(tr_done[(base2 + fl2) % TR]), 1);
    txen = 1'b0;
    baud = 2'd0;
    tick();

    // Reset in DATA bit 3 of 0x96 (that bit is 0).
    mark = cyc;
    txen = 1'b1;
    push(8'h96);
    push(8'h11);
    repeat (19) tick();
    check_eq("pre_rst_txd", 32'(txd), 0);
    rst  = 1'b1;
    txen = 1'b0;
    tick();
    check_eq("mid_rst_txd", 32'(txd), 1);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_ren", 32'(fifo_ren), 0);
    repeat (3) tick();
    check_eq("mid_rst_pops", cnt_sig(SEL_REN, mark, cyc - mark), 1);
    check_eq("mid_rst_head", 32'(fifo_rdata), 32'h11);
    rst = 1'b0;
    wr_ptr = rd_ptr;
    tick();

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity 1, odd parity 0.
    mark = cyc;
    par_odd = 1'b0;
    txen = 1'b1;
    push(8'h07);
    repeat (FL + 5) tick();
    base = mark + 1;
    frame_check("par_even", base, P0, 8'h07);
    check_eq("par_even_bit", 32'(tr_txd[(base + 1 + 9 * P0) % TR]), 1);
    check_eq("par_len", 32'(tr_done[(base + 11 * P0 + 1) % TR]), 1);
    mark = cyc;
    par_odd = 1'b1;
    push(8'h07);
    repeat (FL + 5) tick();
    base = mark + 1;
    frame_check("par_odd", base, P0, 8'h07);
    check_eq("par_odd_bit", 32'(tr_txd[(base + 1 + 9 * P0) % TR]), 0);
    txen = 1'b0;
`endif

    check_eq("ren_while_empty", ren_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
